vsmac_stream: RTL and testbench
===============================

Name: vsmac_stream

Overview:
- Next-generation vector-scalar multiply-accumulate engine.
- SIZE parallel lanes each accumulate a[i]*b over a run-time programmable number of beats, with a widened accumulator, selectable signed/unsigned arithmetic, and saturating or wrapping overflow.
- Input and output use valid/ready handshakes, so the block can sit between a weight/activation streamer and a downstream activation stage in the neural-network datapath without fixed cycle alignment.

Parameters:
- SIZE, 6, number of lanes (a elements).
- WIDTH, 8, width of each a element and of b.
- ACC_WIDTH, 20, per-lane accumulator/output width; must be >= 2*WIDTH.
- MAX_ACC, 16, maximum accumulation length.
- SIGNED, 1, 1 = two's-complement operands; 0 = unsigned.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk, input, 1, single clock; all logic on posedge.
- reset, input, 1, synchronous, active-low reset.
- start, input, 1, begin a new accumulation run.
- acc_len, input, $clog2(MAX_ACC+1), beats per run; sampled with start.
- in_valid, input, 1, a/b beat valid.
- in_ready, output, 1, block accepts a beat.
- a, input, WIDTH*SIZE, lane operands; lane i = a[WIDTH*i +: WIDTH].
- b, input, WIDTH, scalar common to all lanes.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts result.
- out, output, ACC_WIDTH*SIZE, lane results; lane i = out[ACC_WIDTH*i +: ACC_WIDTH].
- done, output, 1, one-cycle pulse when a result first becomes valid.
- busy, output, 1, high when state != IDLE.
- overflow, output, SIZE, sticky per-lane overflow flags for the current run.

Behaviour:

Reset:
- When reset==0 at posedge: state=IDLE; accumulators, beat counter, out, out_valid, in_ready, done, busy and overflow all go to 0.
- Reset applies at any point, including mid-run; any partial result is discarded.

States: IDLE, ACCUM, HOLD.

IDLE:
- in_ready=0, out_valid=0.
- start with acc_len>=1: clear accumulators and overflow, latch len = min(acc_len, MAX_ACC), count=0, go to ACCUM.
- start with acc_len==0: ignored; stay in IDLE.

ACCUM:
- in_ready=1.
- Beat accepted when in_valid && in_ready. On each beat, for every lane: product = a[i]*b (2*WIDTH bits, signed or unsigned per SIGNED), extended to ACC_WIDTH, added to acc[i]; count++.
- Cycles with in_valid==0 leave state unchanged.
- start is ignored in this state.
- When the beat that makes count==len is accepted: out <= final acc values (including that beat), out_valid=1 and done=1 on the next cycle, state goes to HOLD.
- Latency from the last accepted beat to out_valid is exactly 1 cycle.

Overflow:
- Detected per lane per beat when the true sum falls outside the ACC_WIDTH range. Signed range is [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; unsigned range is [0, 2^ACC_WIDTH-1].
- SATURATE=1: acc clamps to the range bound; later beats continue from the clamped value.
- SATURATE=0: acc wraps.
- In both modes overflow[i] is set and stays set until the next start or reset.

HOLD:
- out, out_valid and overflow are held stable; in_ready=0.
- done is high only on the first HOLD cycle.
- On out_valid && out_ready:
  - If start is also high (acc_len>=1), the block goes directly to ACCUM with a cleared run (back-to-back, no IDLE cycle).
  - Otherwise it goes to IDLE.
- out_valid drops in the cycle after acceptance. out keeps its last value until the next result is loaded.
- start without out_ready is ignored.

Outputs: busy is a registered/state-derived signal and is 1 in ACCUM and HOLD.

Test Plan:
1. Basic run (SIZE=2, SIGNED=1): start, acc_len=3, a={lane1=3, lane0=2}, b=4,5,6 on consecutive cycles -> out lane0=30, lane1=45. out_valid and done rise 1 cycle after the 3rd beat; done lasts 1 cycle; overflow=0.
2. Input bubbles: same stimulus as test 1 with in_valid low for 2 cycles between beats -> identical result, out_valid 1 cycle after the 3rd accepted beat, no early done.
3. Signed extremes: acc_len=1, lane0=-128, lane1=127, b=-128 -> lane0=16384, lane1=-16256. Repeat with SIGNED=0 and a=255, b=255 -> 65025.
4. Overflow (ACC_WIDTH=16, SIGNED=1): acc_len=2, lane0=-128, b=-128 twice.
   - SATURATE=1 -> lane0=32767, overflow[0]=1, overflow[1]=0.
   - SATURATE=0 -> lane0=-32768, overflow[0]=1.
5. Backpressure: out_ready low for 5 cycles after a result -> out stable, in_ready=0, start ignored. Then out_ready=1 with start=1, acc_len=2 -> ACCUM next cycle, overflow cleared, new run of 2 beats correct.
6. Reset mid-run: drop reset for 1 cycle after 2 of 4 beats -> all outputs 0, state IDLE; a fresh start with acc_len=1, a lane0=5, b=7 -> lane0=35, with no residue from the aborted run.

Source files
------------

// File: rtl/vsmac_stream.sv
//==============================================================================
// Module  : vsmac_stream
// Brief   : Vector-scalar multiply-accumulate engine; SIZE lanes accumulate
//           a[i]*b over a programmable run length with valid/ready streaming.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module vsmac_stream #(
    parameter int SIZE      = 6,
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 20,
    parameter int MAX_ACC   = 16,
    parameter int SIGNED    = 1,
    parameter int SATURATE  = 1,
    localparam int LEN_W    = $clog2(MAX_ACC + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [LEN_W-1:0]          acc_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH*SIZE-1:0]     a,
    input  logic [WIDTH-1:0]          b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_WIDTH*SIZE-1:0] out,
    output logic                      done,
    output logic                      busy,
    output logic [SIZE-1:0]           overflow
);

    localparam logic [1:0]       c_ST_IDLE  = 2'd0;
    localparam logic [1:0]       c_ST_ACCUM = 2'd1;
    localparam logic [1:0]       c_ST_HOLD  = 2'd2;
    localparam logic [LEN_W-1:0] c_MAX_LEN  = LEN_W'(MAX_ACC);

    logic [1:0]                       r_state;
    logic [1:0]                       w_state_next;
    logic [LEN_W-1:0]                 r_len;
    logic [LEN_W-1:0]                 r_count;
    logic [SIZE-1:0][ACC_WIDTH-1:0]   r_acc;
    logic [SIZE-1:0][ACC_WIDTH-1:0]   r_out;
    logic [SIZE-1:0][ACC_WIDTH-1:0]   w_acc_next;
    logic [SIZE-1:0]                  w_ovf;
    logic [SIZE-1:0]                  r_ovf;
    logic                             r_done;
    logic                             w_start_ok;
    logic                             w_beat;
    logic                             w_last;
    logic                             w_load;

    assign w_start_ok = start && (acc_len != '0);
    assign w_beat     = in_valid && (r_state == c_ST_ACCUM);
    assign w_last     = w_beat && ((r_count + 1'b1) == r_len);
    // A new run may be armed from IDLE, or straight out of HOLD as the result drains
    assign w_load     = w_start_ok && ((r_state == c_ST_IDLE) ||
                                       ((r_state == c_ST_HOLD) && out_ready));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) w_state_next = c_ST_ACCUM;
            end
            c_ST_ACCUM: begin
                if (w_last) w_state_next = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                if (out_ready) w_state_next = w_start_ok ? c_ST_ACCUM : c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < SIZE; gi++) begin : g_lane
            logic [2*WIDTH-1:0]   w_ax;
            logic [2*WIDTH-1:0]   w_bx;
            logic [2*WIDTH-1:0]   w_prod;
            logic [ACC_WIDTH:0]   w_prod_ext;
            logic [ACC_WIDTH:0]   w_acc_ext;
            logic [ACC_WIDTH:0]   w_sum;
            logic [ACC_WIDTH-1:0] w_sat;

            // One guard bit above the accumulator exposes overflow of the true sum
            if (SIGNED != 0) begin : g_signed
                assign w_ax       = {{WIDTH{a[WIDTH*gi+WIDTH-1]}}, a[WIDTH*gi +: WIDTH]};
                assign w_bx       = {{WIDTH{b[WIDTH-1]}}, b};
                assign w_prod_ext = {{(ACC_WIDTH+1-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
                assign w_acc_ext  = {r_acc[gi][ACC_WIDTH-1], r_acc[gi]};
                assign w_ovf[gi]  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
                assign w_sat      = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
            end else begin : g_unsigned
                assign w_ax       = {{WIDTH{1'b0}}, a[WIDTH*gi +: WIDTH]};
                assign w_bx       = {{WIDTH{1'b0}}, b};
                assign w_prod_ext = {{(ACC_WIDTH+1-2*WIDTH){1'b0}}, w_prod};
                assign w_acc_ext  = {1'b0, r_acc[gi]};
                assign w_ovf[gi]  = w_sum[ACC_WIDTH];
                assign w_sat      = {ACC_WIDTH{1'b1}};
            end

            assign w_prod = w_ax * w_bx;
            assign w_sum  = w_acc_ext + w_prod_ext;
            assign w_acc_next[gi] = (w_ovf[gi] && (SATURATE != 0)) ? w_sat
                                                                   : w_sum[ACC_WIDTH-1:0];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_len   <= '0;
            r_count <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_ovf   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_acc   <= '0;
                r_ovf   <= '0;
                r_count <= '0;
                r_len   <= (acc_len > c_MAX_LEN) ? c_MAX_LEN : acc_len;
            end else if (w_beat) begin
                r_acc   <= w_acc_next;
                r_ovf   <= r_ovf | w_ovf;
                r_count <= r_count + 1'b1;
                if (w_last) r_out <= w_acc_next;
            end
        end
    end

    assign in_ready  = (r_state == c_ST_ACCUM);
    assign out_valid = (r_state == c_ST_HOLD);
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = r_done;
    assign out       = r_out;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_vsmac_stream.sv
//==============================================================================
// Module  : tb_vsmac_stream
// Brief   : Self-checking bench for vsmac_stream across four arithmetic configs.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_vsmac_stream;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [4:0]  acc_len = '0;
    logic [47:0] a = '0;
    logic [7:0]  b = '0;

    logic         m_in_ready, m_out_valid, m_done, m_busy;
    logic [119:0] m_out;
    logic [5:0]   m_ovf;
    logic         s_in_ready, s_out_valid, s_done, s_busy;
    logic [31:0]  s_out;
    logic [1:0]   s_ovf;
    logic         w_in_ready, w_out_valid, w_done, w_busy;
    logic [31:0]  w_out;
    logic [1:0]   w_ovf;
    logic         u_in_ready, u_out_valid, u_done, u_busy;
    logic [39:0]  u_out;
    logic [1:0]   u_ovf;

    always #5 clk = ~clk;

    vsmac_stream dut (
        .clk(clk), .reset(reset), .start(start), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(m_in_ready), .a(a), .b(b),
        .out_valid(m_out_valid), .out_ready(out_ready), .out(m_out),
        .done(m_done), .busy(m_busy), .overflow(m_ovf));

    vsmac_stream #(.SIZE(2), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .start(start), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(s_in_ready), .a(a[15:0]), .b(b),
        .out_valid(s_out_valid), .out_ready(out_ready), .out(s_out),
        .done(s_done), .busy(s_busy), .overflow(s_ovf));

    vsmac_stream #(.SIZE(2), .ACC_WIDTH(16), .SIGNED(1), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .start(start), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(w_in_ready), .a(a[15:0]), .b(b),
        .out_valid(w_out_valid), .out_ready(out_ready), .out(w_out),
        .done(w_done), .busy(w_busy), .overflow(w_ovf));

    vsmac_stream #(.SIZE(2), .ACC_WIDTH(20), .SIGNED(0), .SATURATE(1)) dut_u (
        .clk(clk), .reset(reset), .start(start), .acc_len(acc_len),
        .in_valid(in_valid), .in_ready(u_in_ready), .a(a[15:0]), .b(b),
        .out_valid(u_out_valid), .out_ready(out_ready), .out(u_out),
        .done(u_done), .busy(u_busy), .overflow(u_ovf));

    // Arithmetic configuration of each instance: main, saturating, wrapping, unsigned
    int c_size[4] = '{6, 2, 2, 2};
    int c_aw[4]   = '{20, 16, 16, 20};
    bit c_sgn[4]  = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit c_sat[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};

    longint macc[4][6];
    bit     mov[4][6];
    int     phase = 0;
    bit     exp_done = 1'b0;
    bit     chk_en = 1'b0;
    int     exp_len = 0;
    int     nbeat = 0;
    int     n_tests = 0;
    int     n_fail = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint msk(input int aw);
        return (longint'(1) << aw) - 1;
    endfunction

    function automatic longint opnd(input logic [7:0] v, input bit sgn);
        return sgn ? longint'($signed(v)) : longint'(v);
    endfunction

    // True-sum model: add, then clamp or wrap into the accumulator range
    function automatic longint mstep(input longint acc, input longint p, input int aw,
                                     input bit sgn, input bit sat, output bit ovf);
        longint s, lo, hi;
        s   = acc + p;
        lo  = sgn ? -(longint'(1) << (aw - 1)) : 0;
        hi  = sgn ? (longint'(1) << (aw - 1)) - 1 : msk(aw);
        ovf = (s > hi) || (s < lo);
        if (ovf) begin
            if (sat) begin
                s = (s > hi) ? hi : lo;
            end else begin
                s = s & msk(aw);
                if (s > hi) s = s - (longint'(1) << aw);
            end
        end
        return s;
    endfunction

    function automatic longint dut_lane(input int c, input int i);
        case (c)
            0:       return longint'(m_out[20*i +: 20]);
            1:       return longint'(s_out[16*i +: 16]);
            2:       return longint'(w_out[16*i +: 16]);
            default: return longint'(u_out[20*i +: 20]);
        endcase
    endfunction

    function automatic longint dut_ovf(input int c, input int i);
        case (c)
            0:       return longint'(m_ovf[i]);
            1:       return longint'(s_ovf[i]);
            2:       return longint'(w_ovf[i]);
            default: return longint'(u_ovf[i]);
        endcase
    endfunction

    function automatic logic [47:0] lanes(input int l0, input int l1, input int l2,
                                          input int l3, input int l4, input int l5);
        return {8'(l5), 8'(l4), 8'(l3), 8'(l2), 8'(l1), 8'(l0)};
    endfunction

    task automatic model_clear();
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 6; i++) begin
                macc[c][i] = 0;
                mov[c][i]  = 1'b0;
            end
    endtask

    task automatic model_beat(input logic [47:0] av, input logic [7:0] bv);
        bit o;
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < c_size[c]; i++) begin
                macc[c][i] = mstep(macc[c][i], opnd(av[8*i +: 8], c_sgn[c]) * opnd(bv, c_sgn[c]),
                                   c_aw[c], c_sgn[c], c_sat[c], o);
                mov[c][i] = mov[c][i] | o;
            end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", longint'(m_busy), longint'(phase != 0));
            chk("in_ready", longint'(m_in_ready), longint'(phase == 1));
            chk("out_valid", longint'(m_out_valid), longint'(phase == 2));
            chk("done", longint'(m_done), longint'(exp_done));
            chk("lockstep", longint'({s_out_valid, w_out_valid, u_out_valid, s_in_ready, w_in_ready,
                                      u_in_ready, s_busy, w_busy, u_busy, s_done, w_done, u_done}),
                longint'({{3{phase == 2}}, {3{phase == 1}}, {3{phase != 0}}, {3{exp_done}}}));
            if (phase == 2) begin
                for (int c = 0; c < 4; c++)
                    for (int i = 0; i < c_size[c]; i++) begin
                        chk($sformatf("out cfg%0d lane%0d", c, i), dut_lane(c, i),
                            macc[c][i] & msk(c_aw[c]));
                        chk($sformatf("overflow cfg%0d lane%0d", c, i), dut_ovf(c, i),
                            longint'(mov[c][i]));
                    end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_done = 1'b0;
    endtask

    task automatic t_start(input int len);
        start   = 1'b1;
        acc_len = 5'(len);
        tick();
        start   = 1'b0;
        if (len != 0) begin
            model_clear();
            exp_len = (len > 16) ? 16 : len;
            nbeat   = 0;
            phase   = 1;
        end
    endtask

    task automatic t_beat(input logic [47:0] av, input logic [7:0] bv);
        in_valid = 1'b1;
        a = av;
        b = bv;
        tick();
        in_valid = 1'b0;
        a = {$urandom, $urandom};
        b = 8'($urandom);
        model_beat(av, bv);
        nbeat++;
        if (nbeat == exp_len) begin
            phase    = 2;
            exp_done = 1'b1;
        end
    endtask

    task automatic t_idle(input int n);
        repeat (n) begin
            a = {$urandom, $urandom};
            b = 8'($urandom);
            tick();
        end
    endtask

    task automatic t_accept(input bit st, input int len);
        out_ready = 1'b1;
        start     = st;
        acc_len   = 5'(len);
        tick();
        out_ready = 1'b0;
        start     = 1'b0;
        if (st && len != 0) begin
            model_clear();
            exp_len = (len > 16) ? 16 : len;
            nbeat   = 0;
            phase   = 1;
        end else begin
            phase = 0;
        end
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        chk("reset out", longint'(m_out != '0), 0);
        chk("reset overflow", longint'(m_ovf), 0);
        chk("reset flags", longint'({m_busy, m_out_valid, m_in_ready, m_done}), 0);
        reset  = 1'b1;
        chk_en = 1'b1;

        // Zero-length start is ignored
        t_start(0);
        t_idle(2);

        // Basic run
        t_start(3);
        t_beat(lanes(2, 3, -1, 10, -7, 100), 8'd4);
        t_beat(lanes(2, 3, -1, 10, -7, 100), 8'd5);
        t_beat(lanes(2, 3, -1, 10, -7, 100), 8'd6);
        chk("basic lane0", dut_lane(0, 0), 30);
        chk("basic lane1", dut_lane(0, 1), 45);
        t_idle(1);
        t_accept(1'b0, 0);

        // Input bubbles
        t_start(3);
        t_beat(lanes(2, 3, -1, 10, -7, 100), 8'd4);
        t_idle(2);
        t_beat(lanes(2, 3, -1, 10, -7, 100), 8'd5);
        t_idle(2);
        t_beat(lanes(2, 3, -1, 10, -7, 100), 8'd6);
        chk("bubble lane0", dut_lane(0, 0), 30);
        chk("bubble lane1", dut_lane(0, 1), 45);
        t_accept(1'b0, 0);
        t_idle(1);

        // Signed / unsigned extremes
        t_start(1);
        t_beat(lanes(-128, 127, 5, -5, 0, 1), 8'h80);
        chk("extreme s lane0", dut_lane(0, 0), 16384);
        chk("extreme s lane1", dut_lane(0, 1), 1032320);
        chk("extreme u lane1", dut_lane(3, 1), 16256);
        t_accept(1'b0, 0);
        t_start(1);
        t_beat(lanes(255, 255, 255, 255, 255, 255), 8'hFF);
        chk("extreme u 255x255", dut_lane(3, 0), 65025);
        chk("extreme s -1x-1", dut_lane(0, 0), 1);
        t_accept(1'b0, 0);

        // Overflow at 16-bit accumulator
        t_start(2);
        t_beat(lanes(-128, 1, 0, 0, 0, 0), 8'h80);
        t_beat(lanes(-128, 1, 0, 0, 0, 0), 8'h80);
        chk("sat lane0", dut_lane(1, 0), 32767);
        chk("sat overflow", longint'(s_ovf), 1);
        chk("wrap lane0", dut_lane(2, 0), 32768);
        chk("wrap overflow", longint'(w_ovf), 1);
        chk("wide lane0", dut_lane(0, 0), 32768);
        chk("wide overflow", longint'(m_ovf), 0);

        // Backpressure with ignored starts, then back-to-back restart
        repeat (5) begin
            start   = 1'b1;
            acc_len = 5'd3;
            tick();
        end
        start = 1'b0;
        t_accept(1'b1, 2);
        chk("restart overflow cleared", longint'(s_ovf), 0);
        start   = 1'b1;
        acc_len = 5'd1;
        t_beat(lanes(3, -4, 9, 1, 2, -3), 8'd7);
        start = 1'b0;
        t_beat(lanes(3, -4, 9, 1, 2, -3), 8'hFE);
        chk("restart lane0", dut_lane(0, 0), 15);
        chk("restart lane1", dut_lane(0, 1), 1048556);
        t_accept(1'b0, 0);

        // Over-long run length clamps to 16 beats
        t_start(20);
        for (int i = 0; i < 16; i++)
            t_beat(lanes(-128, 127, i, -i, 50, -50), 8'(i * 17 - 100));
        t_accept(1'b0, 0);

        // Reset mid-run
        t_start(4);
        t_beat(lanes(100, 100, 100, 100, 100, 100), 8'd100);
        t_beat(lanes(100, 100, 100, 100, 100, 100), 8'd100);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        phase = 0;
        chk("midreset out", longint'(m_out != '0), 0);
        chk("midreset sat out", longint'(s_out), 0);
        t_start(1);
        t_beat(lanes(5, 0, 0, 0, 0, 0), 8'd7);
        chk("post-reset lane0", dut_lane(0, 0), 35);
        chk("post-reset lane1", dut_lane(0, 1), 0);
        t_accept(1'b0, 0);
        t_idle(2);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
